// File: rtl/seq_detect_pkg.sv
// Shared constants and sizing helpers for the Moore sequence detector.
package seq_detect_pkg;

  // Source of the default reset pattern; the top slices off LEN bits.
  localparam logic [15:0] PAT_ALL_ONES = 16'hFFFF;

  // Ceiling log2; the state register is clog2(LEN+1) bits wide to hold 0..LEN.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < n) r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/seq_prefix_match.sv
// Combinational longest-prefix search: next matched-prefix length after accepting w.
module seq_prefix_match
  import seq_detect_pkg::*;
#(
  parameter int LEN = 3,
  parameter int SW  = clog2(LEN + 1)
) (
  input  logic [LEN-1:0] pattern_i,
  input  logic [LEN-2:0] history_i,
  input  logic           w_i,
  input  logic           overlap_i,
  input  logic [SW-1:0]  state_i,
  output logic [SW-1:0]  next_k_o
);

  logic [LEN-1:0] seq;
  logic           hit;

  // seq[0] is the incoming bit, seq[j] the bit accepted j cycles earlier.
  // A prefix of length k can only end here if k-1 bits already matched, so
  // candidates are bounded by state+1; this also masks stale history bits.
  always_comb begin
    seq      = {history_i, w_i};
    hit      = 1'b0;
    next_k_o = '0;
    if ((int'(state_i) == LEN) && !overlap_i) begin
      next_k_o = (w_i == pattern_i[0]) ? SW'(1) : '0;
    end else begin
      for (int k = 1; k <= LEN; k++) begin
        hit = (k <= int'(state_i) + 1);
        for (int j = 0; j < k; j++) begin
          if (seq[j] != pattern_i[k-1-j]) hit = 1'b0;
        end
        if (hit) next_k_o = SW'(k);
      end
    end
  end

endmodule

// File: rtl/seq_detect_moore.sv
// Moore serial pattern detector with loadable pattern and saturating match counter.
module seq_detect_moore
  import seq_detect_pkg::*;
#(
  parameter int             LEN      = 3,
  parameter logic [LEN-1:0] PAT_INIT = PAT_ALL_ONES[LEN-1:0],
  parameter int             CNT_W    = 8
) (
  input  logic                      Clock,
  input  logic                      Resetn,
  input  logic                      en,
  input  logic                      w,
  input  logic                      overlap,
  input  logic                      pat_load,
  input  logic [LEN-1:0]            pat_in,
  input  logic                      cnt_clr,
  output logic                      z,
  output logic [clog2(LEN+1)-1:0]   match_len,
  output logic [CNT_W-1:0]          match_cnt,
  output logic                      cnt_sat
);

  localparam int SW = clog2(LEN + 1);
  localparam logic [SW-1:0] ST_IDLE = '0;
  localparam logic [SW-1:0] ST_FULL = SW'(LEN);

  logic [LEN-1:0]   pat_q,   pat_d;
  logic [LEN-2:0]   hist_q,  hist_d;
  logic [SW-1:0]    state_q, state_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [SW-1:0]    next_k;
  logic [LEN-1:0]   seq;
  logic             hit_full;

  seq_prefix_match #(
    .LEN (LEN),
    .SW  (SW)
  ) u_match (
    .pattern_i (pat_q),
    .history_i (hist_q),
    .w_i       (w),
    .overlap_i (overlap),
    .state_i   (state_q),
    .next_k_o  (next_k)
  );

  // pat_load wins over en; the counter only sees edges that land in ST_FULL.
  always_comb begin
    seq      = {hist_q, w};
    pat_d    = pat_q;
    hist_d   = hist_q;
    state_d  = state_q;
    hit_full = 1'b0;
    if (pat_load) begin
      pat_d   = pat_in;
      hist_d  = '0;
      state_d = ST_IDLE;
    end else if (en) begin
      hist_d   = seq[LEN-2:0];
      state_d  = next_k;
      hit_full = (next_k == ST_FULL);
    end
    cnt_d = cnt_q;
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (hit_full && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      pat_q   <= PAT_INIT;
      hist_q  <= '0;
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      pat_q   <= pat_d;
      hist_q  <= hist_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign z         = (state_q == ST_FULL);
  assign match_len = state_q;
  assign match_cnt = cnt_q;
  assign cnt_sat   = &cnt_q;

endmodule

// File: tb/tb_seq_detect_moore.sv
// Scoreboard bench for seq_detect_moore (LEN=3, CNT_W=2) with directed vectors.
module tb_seq_detect_moore;

  localparam int LEN   = 3;
  localparam int CNT_W = 2;
  localparam int SW    = 2;
  localparam int CMAX  = 3;

  logic             Clock = 1'b0;
  logic             Resetn, en, w, overlap, pat_load, cnt_clr;
  logic [LEN-1:0]   pat_in;
  logic             z, cnt_sat;
  logic [SW-1:0]    match_len;
  logic [CNT_W-1:0] match_cnt;

  typedef struct {
    string tag;
    int    len;
    bit    zz;
    int    cnt;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  seq_detect_moore #(
    .LEN      (LEN),
    .PAT_INIT (3'b111),
    .CNT_W    (CNT_W)
  ) dut (
    .Clock     (Clock),
    .Resetn    (Resetn),
    .en        (en),
    .w         (w),
    .overlap   (overlap),
    .pat_load  (pat_load),
    .pat_in    (pat_in),
    .cnt_clr   (cnt_clr),
    .z         (z),
    .match_len (match_len),
    .match_cnt (match_cnt),
    .cnt_sat   (cnt_sat)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // Monitor: every cycle the DUT presents a new state, retire one expectation.
  always @(posedge Clock) begin
    exp_t x;
    #1;
    if (sb.size() != 0) begin
      x = sb.pop_front();
      chk({x.tag, ".match_len"}, int'(match_len), x.len);
      chk({x.tag, ".z"},         int'(z),         int'(x.zz));
      chk({x.tag, ".match_cnt"}, int'(match_cnt), x.cnt);
      chk({x.tag, ".cnt_sat"},   int'(cnt_sat),   (x.cnt == CMAX) ? 1 : 0);
    end
  end

  task automatic step(input string tag, input bit rn, input bit e, input bit wb,
                      input bit ov, input bit pl, input logic [LEN-1:0] pin,
                      input bit clr, input int elen, input bit ez, input int ecnt);
    exp_t x;
    @(negedge Clock);
    Resetn = rn; en = e; w = wb; overlap = ov;
    pat_load = pl; pat_in = pin; cnt_clr = clr;
    x.tag = tag; x.len = elen; x.zz = ez; x.cnt = ecnt;
    sb.push_back(x);
  endtask

  task automatic bitin(input string tag, input bit wb, input bit ov,
                       input int elen, input bit ez, input int ecnt);
    step(tag, 1'b1, 1'b1, wb, ov, 1'b0, 3'b000, 1'b0, elen, ez, ecnt);
  endtask

  task automatic idle(input string tag, input bit wb, input bit clr,
                      input int elen, input bit ez, input int ecnt);
    step(tag, 1'b1, 1'b0, wb, 1'b1, 1'b0, 3'b000, clr, elen, ez, ecnt);
  endtask

  task automatic rst(input string tag);
    step(tag, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 3'b000, 1'b1, 0, 1'b0, 0);
  endtask

  initial begin
    Resetn = 1'b0; en = 1'b0; w = 1'b0; overlap = 1'b1;
    pat_load = 1'b0; pat_in = '0; cnt_clr = 1'b0;

    rst("reset0");
    rst("reset1");

    // Pattern 111, overlapping
    bitin("ov_b1", 1, 1, 1, 0, 0);
    bitin("ov_b2", 1, 1, 2, 0, 0);
    bitin("ov_b3", 1, 1, 3, 1, 1);
    bitin("ov_b4", 1, 1, 3, 1, 2);
    idle("ov_clr",  1, 1, 3, 1, 0);
    idle("ov_hold", 0, 0, 3, 1, 0);

    // Pattern 111, non-overlapping
    rst("rst_nov");
    bitin("nov_b1", 1, 0, 1, 0, 0);
    bitin("nov_b2", 1, 0, 2, 0, 0);
    bitin("nov_b3", 1, 0, 3, 1, 1);
    bitin("nov_b4", 1, 0, 1, 0, 1);
    bitin("nov_b5", 1, 0, 2, 0, 1);
    bitin("nov_b6", 1, 0, 3, 1, 2);
    bitin("nov_b7", 0, 0, 0, 0, 2);

    // Load 101 (w ignored), overlapping 1,0,1,0,1; counter saturates at 3
    step("load101", 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 3'b101, 1'b0, 0, 0, 2);
    bitin("p101_b1", 1, 1, 1, 0, 2);
    bitin("p101_b2", 0, 1, 2, 0, 2);
    bitin("p101_b3", 1, 1, 3, 1, 3);
    bitin("p101_b4", 0, 1, 2, 0, 3);
    bitin("p101_b5", 1, 1, 3, 1, 3);

    // Same stream with en=0 gaps
    step("reload101", 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 3'b101, 1'b0, 0, 0, 3);
    idle("gap_clr", 1, 1, 0, 0, 0);
    bitin("gap_b1", 1, 1, 1, 0, 0);
    idle("gap_h1", 0, 0, 1, 0, 0);
    bitin("gap_b2", 0, 1, 2, 0, 0);
    idle("gap_h2", 1, 0, 2, 0, 0);
    bitin("gap_b3", 1, 1, 3, 1, 1);
    idle("gap_h3", 0, 0, 3, 1, 1);
    bitin("gap_b4", 0, 1, 2, 0, 1);
    idle("gap_h4", 1, 0, 2, 0, 1);
    bitin("gap_b5", 1, 1, 3, 1, 2);

    // Reset beats a same-cycle pat_load of 000: pattern returns to 111
    step("rst_vs_load", 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 3'b000, 1'b0, 0, 0, 0);
    bitin("sat_b1", 1, 1, 1, 0, 0);
    bitin("sat_b2", 1, 1, 2, 0, 0);
    bitin("sat_b3", 1, 1, 3, 1, 1);
    bitin("sat_b4", 1, 1, 3, 1, 2);
    bitin("sat_b5", 1, 1, 3, 1, 3);
    bitin("sat_b6", 1, 1, 3, 1, 3);
    step("clr_vs_inc", 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 3'b000, 1'b1, 3, 1, 0);
    bitin("after_clr", 1, 1, 3, 1, 1);

    // Reset mid-match discards progress
    rst("rst_pre");
    bitin("mid_b1", 1, 1, 1, 0, 0);
    bitin("mid_b2", 1, 1, 2, 0, 0);
    step("mid_rst", 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 3'b000, 1'b0, 0, 0, 0);
    bitin("mid_b3", 1, 1, 1, 0, 0);
    bitin("mid_b4", 1, 1, 2, 0, 0);
    bitin("mid_b5", 1, 1, 3, 1, 1);

    // pat_load with en from state 2: w ignored, counter untouched
    bitin("pl_b0", 0, 1, 0, 0, 1);
    bitin("pl_b1", 1, 1, 1, 0, 1);
    bitin("pl_b2", 1, 1, 2, 0, 1);
    step("pl_en", 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 3'b111, 1'b0, 0, 0, 1);
    bitin("pl_b3", 1, 1, 1, 0, 1);
    bitin("pl_b4", 1, 1, 2, 0, 1);
    bitin("pl_b5", 1, 1, 3, 1, 2);

    @(negedge Clock);
    en = 1'b0; pat_load = 1'b0; cnt_clr = 1'b0;
    @(negedge Clock);
    @(negedge Clock);
    chk("scoreboard_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seq_detect_moore.md
SEQ_DETECT_MOORE -- requirements
Module: seq_detect_moore

Interface
REQ-001 Parameter LEN, default 3: pattern length in bits, legal range 2..16.
REQ-002 Parameter PAT_INIT, default all ones (LEN bits): pattern loaded at reset.
REQ-003 Parameter CNT_W, default 8: match counter width, legal range 2..32.
REQ-004 Clock  input  1: single clock; all state updates on its rising edge.
REQ-005 Resetn  input  1: reset, synchronous and active-low.
REQ-006 en  input  1: w is valid this cycle.
REQ-007 w  input  1: serial data bit, sampled only when en=1.
REQ-008 overlap  input  1: 1 = overlapping detection, 0 = non-overlapping.
REQ-009 pat_load  input  1: load pat_in into the pattern register.
REQ-010 pat_in  input  LEN: new pattern; pat_in[0] is the first bit expected.
REQ-011 cnt_clr  input  1: clear the match counter.
REQ-012 z  output  1: Moore match flag, decoded from state only.
REQ-013 match_len  output  clog2(LEN+1): current matched-prefix length (the FSM state).
REQ-014 match_cnt  output  CNT_W: number of matches seen, saturating.
REQ-015 cnt_sat  output  1: match_cnt is at its all-ones value.

Function
REQ-016 The state SHALL be the matched-prefix length k, 0..LEN; state k means the last k accepted bits equal pat[0..k-1].
REQ-017 A history register SHALL hold the last LEN-1 accepted bits; history and state SHALL change only on en=1 or pat_load=1.
REQ-018 On an accepted bit, the next state SHALL be the largest k' (<=LEN) such that the last k' accepted bits, including w, equal pat[0..k'-1]; if none, 0.
REQ-019 z SHALL equal (state==LEN), so z rises on the cycle after the edge that samples the final pattern bit; it SHALL not depend combinationally on w.
REQ-020 In overlap=1, the search for k' from state LEN SHALL include suffixes of the completed match.
REQ-021 In overlap=0, the search for k' from state LEN SHALL ignore all bits up to and including the completed match: next state is 1 if w==pat[0], else 0.
REQ-022 With en=0 and pat_load=0, state, history and z SHALL hold.
REQ-023 pat_load=1 SHALL load pat_in, clear state and history to 0, and ignore w that cycle; pat_load SHALL take priority over en; match_cnt SHALL be unaffected.
REQ-024 overlap SHALL be sampled per accepted bit; changing it mid-stream SHALL take effect at the next transition out of state LEN.
REQ-025 match_cnt SHALL increment by 1 on each edge at which the next state is LEN, including LEN->LEN in overlap mode.
REQ-026 match_cnt SHALL saturate at 2^CNT_W-1; cnt_sat SHALL be 1 exactly when match_cnt is all ones.
REQ-027 cnt_clr=1 SHALL set match_cnt to 0, and SHALL take priority over a same-cycle increment.

Reset
REQ-028 Resetn=0 at a rising edge SHALL set state=0, history=0, z=0, match_len=0, match_cnt=0, cnt_sat=0 and pattern=PAT_INIT.
REQ-029 Reset SHALL take priority over pat_load, en and cnt_clr; reset mid-match SHALL discard partial progress.

Structure
REQ-030 A shared package seq_detect_pkg SHALL hold the state-width function clog2(LEN+1) and the PAT_INIT default.
REQ-031 The combinational longest-prefix search SHALL be one sub-module, seq_prefix_match (inputs: pattern, history, w, overlap and state; output: next k).
REQ-032 The top SHALL contain only registers, priority logic and the counter.

Verification
(Default stimulus: LEN=3, en=1, one bit per cycle.)
REQ-033 Pattern 111, overlap=1, w=1,1,1,1 -> z=1 after bits 3 and 4; match_cnt=2.
REQ-034 Pattern 111, overlap=0, w=1,1,1,1,1,1 -> z=1 after bits 3 and 6 only; match_cnt=2.
REQ-035 pat_load with 101, overlap=1, w=1,0,1,0,1 -> match_len 1,2,3,2,3; z=1 after bits 3 and 5; en=0 gaps inserted between bits give the same result.
REQ-036 CNT_W=2, pattern 111, overlap=1, six 1s -> match_cnt 1,2,3,3; cnt_sat=1; cnt_clr asserted in the same cycle as a match -> match_cnt=0.
REQ-037 Pattern 111, w=1,1, then Resetn=0 for 1 cycle with w=1 -> match_len=0 and z=0; three further 1s are needed before z=1.
REQ-038 pat_load=1 and en=1 in the same cycle from state 2 -> w ignored; match_len=0; match_cnt unchanged.
